// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared decode constants for the pipeline stages: load/store
//               funct3 encodings, opcode constants, memory-access FSM states
//               and access-size helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

    // Load/store funct3 encodings
    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    // Major opcodes seen by the decode stage
    localparam logic [6:0] c_opc_load  = 7'b0000011;
    localparam logic [6:0] c_opc_store = 7'b0100011;
    localparam logic [6:0] c_opc_op    = 7'b0110011;
    localparam logic [6:0] c_opc_opimm = 7'b0010011;

    // Memory-access stage FSM states
    typedef enum logic [0:0] {
        c_st_idle = 1'b0,
        c_st_busy = 1'b1
    } ma_state_e;

    // Access size after funct3 decode
    typedef enum logic [1:0] {
        c_sz_byte = 2'd0,
        c_sz_half = 2'd1,
        c_sz_word = 2'd2
    } ldst_size_e;

    // Unknown funct3 encodings fall back to a full word access
    function automatic ldst_size_e f_ldst_size(input logic [2:0] code);
        ldst_size_e sz;
        case (code)
            c_f3_b, c_f3_bu: sz = c_sz_byte;
            c_f3_h, c_f3_hu: sz = c_sz_half;
            default:         sz = c_sz_word;
        endcase
        return sz;
    endfunction

    // Only LB and LH sign-extend the loaded value
    function automatic logic f_ld_signed(input logic [2:0] code);
        return (code == c_f3_b) || (code == c_f3_h);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_ldst_align.sv
`default_nettype none
// ============================================================================
// Module      : ldst_align
// Description : Combinational lane logic for the memory-access stage: byte
//               enables, store-data lane replication, misalignment detection
//               and load-data lane extraction with sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module ldst_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  i_code,       // funct3 of the incoming request
    input  logic [1:0]  i_adr_lo,     // byte offset of the incoming request
    input  logic [31:0] i_st_data,    // unaligned store data
    input  logic [2:0]  i_ld_code,    // funct3 of the outstanding load
    input  logic [1:0]  i_ld_adr_lo,  // byte offset of the outstanding load
    input  logic [31:0] i_rdata,      // raw memory read word
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misalign,
    output logic [31:0] o_ld_data
);

    ldst_size_e  w_req_size;
    ldst_size_e  w_ld_size;
    logic        w_ld_signed;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_req_size  = f_ldst_size(i_code);
    assign w_ld_size   = f_ldst_size(i_ld_code);
    assign w_ld_signed = f_ld_signed(i_ld_code);

    // Request side: enables, replicated write data and alignment check
    always_comb begin
        o_be       = 4'b1111;
        o_wdata    = i_st_data;
        o_misalign = 1'b0;
        case (w_req_size)
            c_sz_byte: begin
                o_be    = 4'b0001 << i_adr_lo;
                o_wdata = {4{i_st_data[7:0]}};
            end
            c_sz_half: begin
                o_be       = i_adr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_st_data[15:0]}};
                o_misalign = i_adr_lo[0];
            end
            default: begin
                o_be       = 4'b1111;
                o_wdata    = i_st_data;
                o_misalign = |i_adr_lo;
            end
        endcase
    end

    // Load side: pick the addressed lane and extend it to 32 bits
    always_comb begin
        case (i_ld_adr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_ld_adr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (w_ld_size)
            c_sz_byte: o_ld_data = w_ld_signed ? {{24{w_byte[7]}}, w_byte}
                                               : {24'b0, w_byte};
            c_sz_half: o_ld_data = w_ld_signed ? {{16{w_half[15]}}, w_half}
                                               : {16'b0, w_half};
            default:   o_ld_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Pipeline memory-access stage. Passes ALU results to write-back,
//               issues aligned loads/stores to data memory with a
//               request/acknowledge handshake, and flags misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DMEM_AW = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_ld_ma,
    input  logic               cmd_st_ma,
    input  logic               wbk_rd_reg_ma,
    input  logic [4:0]         rd_adr_ma,
    input  logic [31:0]        rd_data_ma,
    input  logic [31:0]        st_data_ma,
    input  logic [2:0]         ldst_code_ma,
    output logic               stall_ma,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_adr,
    output logic [3:0]         dmem_be,
    output logic [31:0]        dmem_wdata,
    input  logic [31:0]        dmem_rdata,
    input  logic               dmem_ack,
    output logic               wbk_rd_reg_wb,
    output logic [4:0]         rd_adr_wb,
    output logic [31:0]        rd_data_wb,
    output logic               ma_misalign
);

    ma_state_e          r_state_q,       w_state_d;
    logic               r_req_q,         w_req_d;
    logic               r_we_q,          w_we_d;
    logic [DMEM_AW-1:0] r_adr_q,         w_adr_d;
    logic [3:0]         r_be_q,          w_be_d;
    logic [31:0]        r_wdata_q,       w_wdata_d;
    logic [2:0]         r_ld_code_q,     w_ld_code_d;
    logic [1:0]         r_ld_adr_lo_q,   w_ld_adr_lo_d;
    logic [4:0]         r_rd_q,          w_rd_d;
    logic               r_wbk_q,         w_wbk_d;
    logic [4:0]         r_rd_adr_wb_q,   w_rd_adr_wb_d;
    logic [31:0]        r_rd_data_wb_q,  w_rd_data_wb_d;
    logic               r_misalign_q,    w_misalign_d;

    logic               w_is_mem;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic               w_misalign;
    logic [31:0]        w_ld_data;
    logic               w_unused_bits;

    // A simultaneous ld+st collapses to a store via the write-enable below
    assign w_is_mem = cmd_ld_ma | cmd_st_ma;

    // Address bits above the data-memory window are not decoded here
    assign w_unused_bits = &{1'b0, rd_data_ma[31:DMEM_AW+2]};

    ldst_align u_ldst_align (
        .i_code      (ldst_code_ma),
        .i_adr_lo    (rd_data_ma[1:0]),
        .i_st_data   (st_data_ma),
        .i_ld_code   (r_ld_code_q),
        .i_ld_adr_lo (r_ld_adr_lo_q),
        .i_rdata     (dmem_rdata),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_misalign  (w_misalign),
        .o_ld_data   (w_ld_data)
    );

    // Next-state and next-output logic for the IDLE/BUSY handshake FSM
    always_comb begin
        w_state_d      = r_state_q;
        w_req_d        = r_req_q;
        w_we_d         = r_we_q;
        w_adr_d        = r_adr_q;
        w_be_d         = r_be_q;
        w_wdata_d      = r_wdata_q;
        w_ld_code_d    = r_ld_code_q;
        w_ld_adr_lo_d  = r_ld_adr_lo_q;
        w_rd_d         = r_rd_q;
        w_rd_adr_wb_d  = r_rd_adr_wb_q;
        w_rd_data_wb_d = r_rd_data_wb_q;
        w_wbk_d        = 1'b0;
        w_misalign_d   = 1'b0;
        case (r_state_q)
            c_st_idle: begin
                if (w_is_mem) begin
                    if (w_misalign) begin
                        // Dropped access: flag it, no request, no write-back
                        w_misalign_d = 1'b1;
                    end else begin
                        w_state_d     = c_st_busy;
                        w_req_d       = 1'b1;
                        w_we_d        = cmd_st_ma;
                        w_adr_d       = rd_data_ma[DMEM_AW+1:2];
                        w_be_d        = w_be;
                        w_wdata_d     = w_wdata;
                        w_ld_code_d   = ldst_code_ma;
                        w_ld_adr_lo_d = rd_data_ma[1:0];
                        w_rd_d        = rd_adr_ma;
                    end
                end else begin
                    w_rd_adr_wb_d  = rd_adr_ma;
                    w_rd_data_wb_d = rd_data_ma;
                    w_wbk_d        = wbk_rd_reg_ma & (|rd_adr_ma);
                end
            end
            c_st_busy: begin
                if (r_req_q && dmem_ack) begin
                    w_state_d = c_st_idle;
                    w_req_d   = 1'b0;
                    w_we_d    = 1'b0;
                    if (!r_we_q) begin
                        w_rd_adr_wb_d  = r_rd_q;
                        w_rd_data_wb_d = w_ld_data;
                        w_wbk_d        = |r_rd_q;
                    end
                end
            end
            default: begin
                w_state_d = c_st_idle;
                w_req_d   = 1'b0;
                w_we_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q      <= c_st_idle;
            r_req_q        <= 1'b0;
            r_we_q         <= 1'b0;
            r_adr_q        <= '0;
            r_be_q         <= 4'b0;
            r_wdata_q      <= 32'b0;
            r_ld_code_q    <= 3'b0;
            r_ld_adr_lo_q  <= 2'b0;
            r_rd_q         <= 5'b0;
            r_wbk_q        <= 1'b0;
            r_rd_adr_wb_q  <= 5'b0;
            r_rd_data_wb_q <= 32'b0;
            r_misalign_q   <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_req_q        <= w_req_d;
            r_we_q         <= w_we_d;
            r_adr_q        <= w_adr_d;
            r_be_q         <= w_be_d;
            r_wdata_q      <= w_wdata_d;
            r_ld_code_q    <= w_ld_code_d;
            r_ld_adr_lo_q  <= w_ld_adr_lo_d;
            r_rd_q         <= w_rd_d;
            r_wbk_q        <= w_wbk_d;
            r_rd_adr_wb_q  <= w_rd_adr_wb_d;
            r_rd_data_wb_q <= w_rd_data_wb_d;
            r_misalign_q   <= w_misalign_d;
        end
    end

    assign stall_ma      = (r_state_q == c_st_busy);
    assign dmem_req      = r_req_q;
    assign dmem_we       = r_we_q;
    assign dmem_adr      = r_adr_q;
    assign dmem_be       = r_be_q;
    assign dmem_wdata    = r_wdata_q;
    assign wbk_rd_reg_wb = r_wbk_q;
    assign rd_adr_wb     = r_rd_adr_wb_q;
    assign rd_data_wb    = r_rd_data_wb_q;
    assign ma_misalign   = r_misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit. Table of operations
//               with expected request/write-back values, a write-back
//               scoreboard queue, and hand sequences for reset and stray acks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int DMEM_AW = 14;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cmd_ld_ma, cmd_st_ma, wbk_rd_reg_ma;
    logic [4:0]         rd_adr_ma;
    logic [31:0]        rd_data_ma, st_data_ma;
    logic [2:0]         ldst_code_ma;
    logic               stall_ma, dmem_req, dmem_we;
    logic [DMEM_AW-1:0] dmem_adr;
    logic [3:0]         dmem_be;
    logic [31:0]        dmem_wdata, dmem_rdata;
    logic               dmem_ack;
    logic               wbk_rd_reg_wb;
    logic [4:0]         rd_adr_wb;
    logic [31:0]        rd_data_wb;
    logic               ma_misalign;

    mem_access_unit #(.DMEM_AW(DMEM_AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_ld_ma     (cmd_ld_ma),
        .cmd_st_ma     (cmd_st_ma),
        .wbk_rd_reg_ma (wbk_rd_reg_ma),
        .rd_adr_ma     (rd_adr_ma),
        .rd_data_ma    (rd_data_ma),
        .st_data_ma    (st_data_ma),
        .ldst_code_ma  (ldst_code_ma),
        .stall_ma      (stall_ma),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_adr      (dmem_adr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .wbk_rd_reg_wb (wbk_rd_reg_wb),
        .rd_adr_wb     (rd_adr_wb),
        .rd_data_wb    (rd_data_wb),
        .ma_misalign   (ma_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ld;
        logic        st;
        logic        wbk;
        logic [4:0]  rd;
        logic [31:0] adr;
        logic [31:0] st_data;
        logic [2:0]  code;
        logic [31:0] rdata;
        int          busy;       // stall cycles; ack is given in the last one
        logic        exp_mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_wbk;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        string       name;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    int  total = 0;
    int  bad   = 0;
    wb_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic ld, input logic st,
                                input logic wbk, input logic [4:0] rd,
                                input logic [31:0] adr, input logic [31:0] sd,
                                input logic [2:0] code, input logic [31:0] rdata,
                                input int busy, input logic mis, input logic [3:0] be,
                                input logic [31:0] wd, input logic ewbk,
                                input logic [31:0] edata);
        vec_t v;
        v.name = n; v.ld = ld; v.st = st; v.wbk = wbk; v.rd = rd; v.adr = adr;
        v.st_data = sd; v.code = code; v.rdata = rdata; v.busy = busy;
        v.exp_mis = mis; v.exp_be = be; v.exp_wdata = wd; v.exp_wbk = ewbk;
        v.exp_data = edata;
        return v;
    endfunction

    // Write-back monitor: every wbk pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wbk_rd_reg_wb === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_wbk: got rd=%0d data=%h want no write-back",
                         rd_adr_wb, rd_data_wb);
            end else begin
                wb_t e;
                e = sb.pop_front();
                chk({e.name, "_wb_rd"}, {27'b0, rd_adr_wb}, {27'b0, e.rd});
                chk({e.name, "_wb_data"}, rd_data_wb, e.data);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    // Called at a negedge with the DUT idle; returns at a negedge, DUT idle
    task automatic run_vec(input vec_t v);
        int stalls;
        logic [31:0] exp_adr;
        exp_adr = (v.adr >> 2) & 32'h0000_3FFF;
        cmd_ld_ma     = v.ld;
        cmd_st_ma     = v.st;
        wbk_rd_reg_ma = v.wbk;
        rd_adr_ma     = v.rd;
        rd_data_ma    = v.adr;
        st_data_ma    = v.st_data;
        ldst_code_ma  = v.code;
        if (v.exp_wbk) sb.push_back('{v.name, v.rd, v.exp_data});
        @(negedge clk);
        cmd_ld_ma     = 1'b0;
        cmd_st_ma     = 1'b0;
        wbk_rd_reg_ma = 1'b0;
        rd_adr_ma     = 5'd0;
        rd_data_ma    = 32'h0;
        if (!(v.ld || v.st)) begin
            chk({v.name, "_stall"}, {31'b0, stall_ma}, 32'd0);
            chk({v.name, "_req"}, {31'b0, dmem_req}, 32'd0);
        end else if (v.exp_mis) begin
            chk({v.name, "_mis"}, {31'b0, ma_misalign}, 32'd1);
            chk({v.name, "_req"}, {31'b0, dmem_req}, 32'd0);
            chk({v.name, "_stall"}, {31'b0, stall_ma}, 32'd0);
            @(negedge clk);
            chk({v.name, "_mis_end"}, {31'b0, ma_misalign}, 32'd0);
            chk({v.name, "_req_none"}, {31'b0, dmem_req}, 32'd0);
        end else begin
            chk({v.name, "_we"}, {31'b0, dmem_we}, {31'b0, v.st});
            chk({v.name, "_adr"}, {18'b0, dmem_adr}, exp_adr);
            chk({v.name, "_be"}, {28'b0, dmem_be}, {28'b0, v.exp_be});
            if (v.st) chk({v.name, "_wdata"}, dmem_wdata, v.exp_wdata);
            stalls = 0;
            while (stall_ma === 1'b1 && stalls < 40) begin
                stalls++;
                chk({v.name, "_req_hold"}, {31'b0, dmem_req}, 32'd1);
                if (stalls == v.busy) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = v.rdata;
                end
                @(negedge clk);
                dmem_ack   = 1'b0;
                dmem_rdata = 32'hBAD0_BAD0;
            end
            chk({v.name, "_stall_cycles"}, stalls, v.busy);
            chk({v.name, "_req_drop"}, {31'b0, dmem_req}, 32'd0);
        end
    endtask

    vec_t vt[$];

    initial begin
        vt.push_back(mk("alu_rd7",  0,0,1, 7, 32'h1111_2222, 32'h0, 3'b000, 32'h0, 0, 0, 4'h0, 32'h0, 1, 32'h1111_2222));
        vt.push_back(mk("alu_rd0",  0,0,1, 0, 32'h3333_4444, 32'h0, 3'b000, 32'h0, 0, 0, 4'h0, 32'h0, 0, 32'h0));
        vt.push_back(mk("lw_100",   1,0,1, 5, 32'h100, 32'h0, 3'b010, 32'hDEAD_BEEF, 3, 0, 4'hF, 32'h0, 1, 32'hDEAD_BEEF));
        vt.push_back(mk("lb_103",   1,0,1, 6, 32'h103, 32'h0, 3'b000, 32'h80FF_0000, 1, 0, 4'h8, 32'h0, 1, 32'hFFFF_FF80));
        vt.push_back(mk("lbu_103",  1,0,1, 6, 32'h103, 32'h0, 3'b100, 32'h80FF_0000, 2, 0, 4'h8, 32'h0, 1, 32'h0000_0080));
        vt.push_back(mk("sh_202",   0,1,0, 0, 32'h202, 32'h1234_ABCD, 3'b001, 32'h0, 1, 0, 4'hC, 32'hABCD_ABCD, 0, 32'h0));
        vt.push_back(mk("lw_101",   1,0,1, 5, 32'h101, 32'h0, 3'b010, 32'h0, 0, 1, 4'h0, 32'h0, 0, 32'h0));
        vt.push_back(mk("lh_102",   1,0,1, 9, 32'h102, 32'h0, 3'b001, 32'h8001_7FFF, 1, 0, 4'hC, 32'h0, 1, 32'hFFFF_8001));
        vt.push_back(mk("lhu_102",  1,0,1,10, 32'h102, 32'h0, 3'b101, 32'h8001_7FFF, 4, 0, 4'hC, 32'h0, 1, 32'h0000_8001));
        vt.push_back(mk("lh_000",   1,0,1,14, 32'h000, 32'h0, 3'b001, 32'h0000_9ABC, 1, 0, 4'h3, 32'h0, 1, 32'hFFFF_9ABC));
        vt.push_back(mk("sb_001",   0,1,0, 0, 32'h001, 32'h0000_00A5, 3'b000, 32'h0, 1, 0, 4'h2, 32'hA5A5_A5A5, 0, 32'h0));
        vt.push_back(mk("lh_103",   1,0,1, 9, 32'h103, 32'h0, 3'b001, 32'h0, 0, 1, 4'h0, 32'h0, 0, 32'h0));
        vt.push_back(mk("sw_302",   0,1,0, 0, 32'h302, 32'h1, 3'b010, 32'h0, 0, 1, 4'h0, 32'h0, 0, 32'h0));
        vt.push_back(mk("ld_f3_011",1,0,1,11, 32'h104, 32'h0, 3'b011, 32'h0123_4567, 1, 0, 4'hF, 32'h0, 1, 32'h0123_4567));
        vt.push_back(mk("ldst_both",1,1,1,12, 32'h108, 32'hCAFE_F00D, 3'b010, 32'hFFFF_FFFF, 2, 0, 4'hF, 32'hCAFE_F00D, 0, 32'h0));
        vt.push_back(mk("lb_rd0",   1,0,1, 0, 32'h100, 32'h0, 3'b000, 32'h0000_00AA, 1, 0, 4'h1, 32'h0, 0, 32'h0));
        vt.push_back(mk("sw_010",   0,1,0, 0, 32'h010, 32'h55AA_55AA, 3'b010, 32'h0, 2, 0, 4'hF, 32'h55AA_55AA, 0, 32'h0));
        vt.push_back(mk("st_f3_110",0,1,0, 0, 32'h020, 32'h8765_4321, 3'b110, 32'h0, 1, 0, 4'hF, 32'h8765_4321, 0, 32'h0));
        vt.push_back(mk("lb_102",   1,0,1,13, 32'h102, 32'h0, 3'b000, 32'h0042_0000, 1, 0, 4'h4, 32'h0, 1, 32'h0000_0042));
        vt.push_back(mk("alu_rd31", 0,0,1,31, 32'hA5A5_5A5A, 32'h0, 3'b000, 32'h0, 0, 0, 4'h0, 32'h0, 1, 32'hA5A5_5A5A));
        vt.push_back(mk("alu_nowbk",0,0,0, 4, 32'h7777_7777, 32'h0, 3'b000, 32'h0, 0, 0, 4'h0, 32'h0, 0, 32'h0));

        rst_n         = 1'b0;
        cmd_ld_ma     = 1'b0;
        cmd_st_ma     = 1'b0;
        wbk_rd_reg_ma = 1'b0;
        rd_adr_ma     = 5'd0;
        rd_data_ma    = 32'h0;
        st_data_ma    = 32'h0;
        ldst_code_ma  = 3'b000;
        dmem_rdata    = 32'h0;
        dmem_ack      = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_stall",   {31'b0, stall_ma},      32'd0);
        chk("rst_req",     {31'b0, dmem_req},      32'd0);
        chk("rst_we",      {31'b0, dmem_we},       32'd0);
        chk("rst_adr",     {18'b0, dmem_adr},      32'd0);
        chk("rst_be",      {28'b0, dmem_be},       32'd0);
        chk("rst_wdata",   dmem_wdata,             32'd0);
        chk("rst_wbk",     {31'b0, wbk_rd_reg_wb}, 32'd0);
        chk("rst_rd_adr",  {27'b0, rd_adr_wb},     32'd0);
        chk("rst_rd_data", rd_data_wb,             32'd0);
        chk("rst_mis",     {31'b0, ma_misalign},   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Stray ack with no request outstanding must do nothing
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("stray_ack_req",   {31'b0, dmem_req}, 32'd0);
        chk("stray_ack_stall", {31'b0, stall_ma}, 32'd0);
        @(negedge clk);

        // Table: each op starts on the cycle right after the previous one ends
        foreach (vt[i]) run_vec(vt[i]);
        @(negedge clk);

        // Reset while a load is outstanding, then a late ack
        cmd_ld_ma     = 1'b1;
        wbk_rd_reg_ma = 1'b1;
        rd_adr_ma     = 5'd3;
        rd_data_ma    = 32'h200;
        ldst_code_ma  = 3'b010;
        @(negedge clk);
        cmd_ld_ma     = 1'b0;
        wbk_rd_reg_ma = 1'b0;
        chk("rstbusy_req_before", {31'b0, dmem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstbusy_req_async",   {31'b0, dmem_req}, 32'd0);
        chk("rstbusy_stall_async", {31'b0, stall_ma}, 32'd0);
        chk("rstbusy_adr_async",   {18'b0, dmem_adr}, 32'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("rstbusy_wbk_in_rst", {31'b0, wbk_rd_reg_wb}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstbusy_req_after",   {31'b0, dmem_req},      32'd0);
        chk("rstbusy_stall_after", {31'b0, stall_ma},      32'd0);
        chk("rstbusy_wbk_after",   {31'b0, wbk_rd_reg_wb}, 32'd0);
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("rstbusy_wbk_late", {31'b0, wbk_rd_reg_wb}, 32'd0);

        // Unit still works after the abandoned request
        run_vec(mk("post_rst_lw", 1,0,1, 8, 32'h044, 32'h0, 3'b010, 32'h0BAD_F00D, 1, 0, 4'hF, 32'h0, 1, 32'h0BAD_F00D));
        repeat (3) @(negedge clk);

        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
